smvm_stream_tx: RTL and testbench

- Frame serializer that drives the SMVM serial input protocol: rows header, cols header, dense vector, then interleaved value/index pairs for the sparse matrix.
- Host software loads the vector and the CSR-ordered nonzeros through append ports, then pulses start.
- The block emits one contiguous frame, pads the nonzero count to a multiple of K, and holds a guard gap so the accelerator can finish its CAL/OUT sequence.
- It sits between the host/testbench loader and the SMVM input port.

---
 rtl/smvm_pkg.sv | 38 +++
 rtl/smvm_stream_tx_if.sv | 33 +++
 rtl/smvm_tx_buf.sv | 44 ++++
 rtl/smvm_stream_tx.sv | 183 ++++++++++++++++++
 tb/tb_smvm_stream_tx.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smvm_pkg.sv
// Shared SMVM definitions: transmit FSM states, frame word layout and the
// consumer's nonzero group size.
package smvm_pkg;

   localparam int unsigned SMVM_K  = 4;
   localparam int unsigned WORD_W  = 12;
   localparam int unsigned VAL_MSB = 11;
   localparam int unsigned IPV_BIT = 3;
   localparam int unsigned COL_MSB = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_R,
      ST_HDR_C,
      ST_VEC,
      ST_NZ_V,
      ST_NZ_I,
      ST_GAP
   } tx_state_e;

   typedef struct packed {
      logic       valid;
      logic [7:0] val;
      logic       ipv;
      logic [2:0] col;
   } tx_beat_t;

   // A 12-bit frame word spread across the val/ipv/col lanes.
   function automatic tx_beat_t word_beat(input logic [WORD_W-1:0] w);
      tx_beat_t b;
      b.valid = 1'b1;
      b.val   = w[VAL_MSB:IPV_BIT+1];
      b.ipv   = w[IPV_BIT];
      b.col   = w[COL_MSB:0];
      return b;
   endfunction

endpackage

// File: rtl/smvm_stream_tx_if.sv
// Host-load, control/status and SMVM transmit signals of smvm_stream_tx.
interface smvm_stream_tx_if;

   logic       vec_wr_en;
   logic [7:0] vec_wr_data;
   logic       nz_wr_en;
   logic [7:0] nz_val;
   logic [6:0] nz_col;
   logic       nz_last;
   logic       start;
   logic [7:0] rows;
   logic [7:0] cols;
   logic       busy;
   logic       done;
   logic       err;
   logic       tx_valid;
   logic [7:0] tx_val;
   logic       tx_ipv;
   logic [2:0] tx_col;

   modport master (
      output vec_wr_en, vec_wr_data, nz_wr_en, nz_val, nz_col, nz_last,
      output start, rows, cols,
      input  busy, done, err, tx_valid, tx_val, tx_ipv, tx_col
   );

   modport slave (
      input  vec_wr_en, vec_wr_data, nz_wr_en, nz_val, nz_col, nz_last,
      input  start, rows, cols,
      output busy, done, err, tx_valid, tx_val, tx_ipv, tx_col
   );

endinterface

// File: rtl/smvm_tx_buf.sv
// Append-only register-array buffer with indexed combinational read and an
// occupancy count; clearing resets the count only.
module smvm_tx_buf #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 128
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_clr,
   input  logic                           i_wr_en,
   input  logic [WIDTH-1:0]               i_wr_data,
   input  logic [$clog2(DEPTH)-1:0]       i_rd_idx,
   output logic [WIDTH-1:0]               o_rd_data,
   output logic [$clog2(DEPTH+1)-1:0]     o_count,
   output logic                           o_full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_rd_data = r_mem[i_rd_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_wr_en && !o_full) begin
         r_count <= r_count + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_wr_en && !o_full) begin
         r_mem[r_count[AW-1:0]] <= i_wr_data;
      end
   end

endmodule

// File: rtl/smvm_stream_tx.sv
// SMVM frame serializer: rows/cols headers, dense vector, then value/index
// pairs padded to a multiple of K, followed by a guard gap.
module smvm_stream_tx
   import smvm_pkg::*;
#(
   parameter int unsigned K          = SMVM_K,
   parameter int unsigned VEC_DEPTH  = 128,
   parameter int unsigned NNZ_DEPTH  = 256,
   parameter int unsigned GAP_CYCLES = 16
) (
   input logic             clk,
   input logic             rst,
   smvm_stream_tx_if.slave bus
);

   localparam int unsigned VA_W = $clog2(VEC_DEPTH);
   localparam int unsigned VC_W = $clog2(VEC_DEPTH + 1);
   localparam int unsigned NA_W = $clog2(NNZ_DEPTH);
   localparam int unsigned NC_W = $clog2(NNZ_DEPTH + 1);

   tx_state_e       r_state, w_state_nxt;
   logic [15:0]     r_idx, w_idx_nxt;
   logic [15:0]     r_gap, w_gap_nxt;
   logic [7:0]      r_rows, r_cols;
   logic [NC_W-1:0] r_last_cnt;
   logic            r_tail_last;
   logic            r_err, r_done;
   tx_beat_t        r_beat, w_beat;

   logic [VC_W-1:0] w_vec_cnt;
   logic [NC_W-1:0] w_nnz_cnt;
   logic [7:0]      w_vec_rd;
   logic [15:0]     w_nz_rd;
   logic [15:0]     w_rem, w_total;
   logic            w_vec_full, w_nz_full, w_idle;
   logic            w_vec_we, w_nz_we, w_clr;
   logic            w_start_ok, w_accept, w_real, w_err;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_vec_we = bus.vec_wr_en && w_idle && !w_vec_full;
   assign w_nz_we  = bus.nz_wr_en && w_idle && !w_nz_full;
   assign w_clr    = (r_state == ST_GAP) && (r_gap == 16'(GAP_CYCLES - 1));

   assign w_start_ok = (bus.rows != '0) && (bus.cols != '0) &&
                       (16'(w_vec_cnt) == 16'(bus.cols)) && (w_nnz_cnt != '0) &&
                       (16'(r_last_cnt) == 16'(bus.rows)) && r_tail_last;
   assign w_accept   = bus.start && w_idle && w_start_ok;
   assign w_err      = (bus.vec_wr_en && !w_vec_we) || (bus.nz_wr_en && !w_nz_we) ||
                       (bus.start && w_idle && !w_start_ok);

   // Entries past the stored nonzeros are zero pads up to the next K boundary.
   assign w_rem   = 16'(w_nnz_cnt) % 16'(K);
   assign w_total = 16'(w_nnz_cnt) + ((w_rem == '0) ? '0 : (16'(K) - w_rem));
   assign w_real  = (r_idx < 16'(w_nnz_cnt));

   smvm_tx_buf #(.WIDTH(8), .DEPTH(VEC_DEPTH)) u_vec_buf (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr),
      .i_wr_en   (w_vec_we),
      .i_wr_data (bus.vec_wr_data),
      .i_rd_idx  (r_idx[VA_W-1:0]),
      .o_rd_data (w_vec_rd),
      .o_count   (w_vec_cnt),
      .o_full    (w_vec_full)
   );

   smvm_tx_buf #(.WIDTH(16), .DEPTH(NNZ_DEPTH)) u_nz_buf (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr),
      .i_wr_en   (w_nz_we),
      .i_wr_data ({bus.nz_val, bus.nz_last, bus.nz_col}),
      .i_rd_idx  (r_idx[NA_W-1:0]),
      .o_rd_data (w_nz_rd),
      .o_count   (w_nnz_cnt),
      .o_full    (w_nz_full)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_gap_nxt   = r_gap;
      w_beat      = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_HDR_R;
               w_idx_nxt   = '0;
               w_gap_nxt   = '0;
            end
         end
         ST_HDR_R: begin
            w_beat      = word_beat(WORD_W'(r_rows));
            w_state_nxt = ST_HDR_C;
         end
         ST_HDR_C: begin
            w_beat      = word_beat(WORD_W'(r_cols));
            w_state_nxt = ST_VEC;
         end
         ST_VEC: begin
            w_beat.valid = 1'b1;
            w_beat.val   = w_vec_rd;
            if (r_idx == 16'(r_cols) - 16'd1) begin
               w_idx_nxt   = '0;
               w_state_nxt = ST_NZ_V;
            end else begin
               w_idx_nxt = r_idx + 16'd1;
            end
         end
         ST_NZ_V: begin
            w_beat.valid = 1'b1;
            if (w_real) begin
               w_beat.val = w_nz_rd[15:8];
               w_beat.ipv = w_nz_rd[7];
            end
            w_state_nxt = ST_NZ_I;
         end
         ST_NZ_I: begin
            w_beat = word_beat(w_real ? WORD_W'(w_nz_rd[6:0]) : '0);
            if (r_idx == w_total - 16'd1) begin
               w_gap_nxt   = '0;
               w_state_nxt = ST_GAP;
            end else begin
               w_idx_nxt   = r_idx + 16'd1;
               w_state_nxt = ST_NZ_V;
            end
         end
         ST_GAP: begin
            if (w_clr) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_gap_nxt = r_gap + 16'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_gap       <= '0;
         r_rows      <= '0;
         r_cols      <= '0;
         r_last_cnt  <= '0;
         r_tail_last <= 1'b0;
         r_err       <= 1'b0;
         r_done      <= 1'b0;
         r_beat      <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_gap   <= w_gap_nxt;
         r_beat  <= w_beat;
         r_err   <= w_err;
         r_done  <= w_clr;
         if (w_accept) begin
            r_rows <= bus.rows;
            r_cols <= bus.cols;
         end
         if (w_clr) begin
            r_last_cnt  <= '0;
            r_tail_last <= 1'b0;
         end else if (w_nz_we) begin
            if (bus.nz_last) begin
               r_last_cnt <= r_last_cnt + NC_W'(1);
            end
            r_tail_last <= bus.nz_last;
         end
      end
   end

   assign bus.busy     = !w_idle;
   assign bus.done     = r_done;
   assign bus.err      = r_err;
   assign bus.tx_valid = r_beat.valid;
   assign bus.tx_val   = r_beat.val;
   assign bus.tx_ipv   = r_beat.ipv;
   assign bus.tx_col   = r_beat.col;

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Directed self-checking bench for smvm_stream_tx: frame content, padding,
// start rejection, write rejection, overflow, async reset and wide indices.
module tb_smvm_stream_tx;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   smvm_stream_tx_if bus();

   smvm_stream_tx #(
      .K          (4),
      .VEC_DEPTH  (128),
      .NNZ_DEPTH  (256),
      .GAP_CYCLES (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0] cap[$];
   int          cap_first, cap_last, cap_done;
   logic        saw_done, err_seen, busy0, valid0;

   task automatic clear_inputs();
      bus.vec_wr_en   = 1'b0;
      bus.vec_wr_data = '0;
      bus.nz_wr_en    = 1'b0;
      bus.nz_val      = '0;
      bus.nz_col      = '0;
      bus.nz_last     = 1'b0;
      bus.start       = 1'b0;
      bus.rows        = '0;
      bus.cols        = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wr_vec(input logic [7:0] d, output logic e);
      @(negedge clk);
      bus.vec_wr_en   = 1'b1;
      bus.vec_wr_data = d;
      @(negedge clk);
      bus.vec_wr_en = 1'b0;
      e = bus.err;
   endtask

   task automatic wr_nz(input logic [7:0] v, input logic [6:0] c, input logic l);
      @(negedge clk);
      bus.nz_wr_en = 1'b1;
      bus.nz_val   = v;
      bus.nz_col   = c;
      bus.nz_last  = l;
      @(negedge clk);
      bus.nz_wr_en = 1'b0;
   endtask

   task automatic pulse_start(input logic [7:0] r, input logic [7:0] c,
                              output logic e, output logic act);
      @(negedge clk);
      bus.rows  = r;
      bus.cols  = c;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      e   = bus.err;
      act = bus.busy | bus.tx_valid;
      repeat (4) begin
         @(negedge clk);
         act = act | bus.busy | bus.tx_valid;
      end
   endtask

   // Starts a frame and records every valid beat until done or a cycle budget.
   task automatic run_frame(input logic [7:0] r, input logic [7:0] c, input int inject_at);
      logic e;
      cap.delete();
      cap_first = -1; cap_last = -1; cap_done = -1;
      saw_done = 1'b0; err_seen = 1'b0;
      @(negedge clk);
      bus.rows  = r;
      bus.cols  = c;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      busy0  = bus.busy;
      valid0 = bus.tx_valid;
      for (int s = 1; s < 400; s++) begin
         if (s == inject_at) begin
            bus.vec_wr_en   = 1'b1;
            bus.vec_wr_data = 8'h55;
         end
         @(negedge clk);
         bus.vec_wr_en = 1'b0;
         e = bus.err;
         if (e) err_seen = 1'b1;
         if (bus.tx_valid) begin
            cap.push_back({bus.tx_val, bus.tx_ipv, bus.tx_col});
            if (cap_first < 0) cap_first = s;
            cap_last = s;
         end
         if (bus.done) begin
            saw_done = 1'b1;
            cap_done = s;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] outs;
      rst = 1'b1;
      clear_inputs();
      repeat (3) @(negedge clk);
      outs = {bus.busy, bus.done, bus.err, bus.tx_valid, bus.tx_val, bus.tx_ipv, bus.tx_col};
      n_checks++;
      if (outs !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0000", outs);
      end
      rst = 1'b0;
      @(negedge clk);
      outs = {bus.busy, bus.done, bus.err, bus.tx_valid, bus.tx_val, bus.tx_ipv, bus.tx_col};
      n_checks++;
      if (outs !== 16'h0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %h expected 0000", outs);
      end
   endtask

   task automatic test_basic_frame();
      logic [11:0] exp_b [13] = '{12'h002, 12'h003, 12'h050, 12'hFF0, 12'h020,
                                  12'h030, 12'h000, 12'hFE8, 12'h002, 12'h078,
                                  12'h001, 12'h000, 12'h000};
      logic e, act;
      wr_vec(8'h05, e); wr_vec(8'hFF, e); wr_vec(8'h02, e);
      wr_nz(8'h03, 7'd0, 1'b0);
      wr_nz(8'hFE, 7'd2, 1'b1);
      wr_nz(8'h07, 7'd1, 1'b1);
      run_frame(8'd2, 8'd3, -1);
      n_checks++;
      if (busy0 !== 1'b1 || valid0 !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_first_cycle: busy=%b valid=%b expected busy=1 valid=0", busy0, valid0);
      end
      n_checks++;
      if (cap_first !== 1) begin
         n_fail++;
         $display("FAIL basic_latency: first valid at %0d expected 1", cap_first);
      end
      n_checks++;
      if (cap.size() !== 13) begin
         n_fail++;
         $display("FAIL basic_length: got %0d beats expected 13", cap.size());
      end
      for (int i = 0; i < 13; i++) begin
         if (i < cap.size()) begin
            n_checks++;
            if (cap[i] !== exp_b[i]) begin
               n_fail++;
               $display("FAIL basic_beat%0d: got %h expected %h", i, cap[i], exp_b[i]);
            end
         end
      end
      n_checks++;
      if (saw_done !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_done_timeout: done seen=%b expected 1", saw_done);
      end else begin
         n_checks++;
         if (cap_done - cap_last !== 16) begin
            n_fail++;
            $display("FAIL basic_gap: got %0d cycles expected 16", cap_done - cap_last);
         end
      end
      pulse_start(8'd2, 8'd3, e, act);
      n_checks++;
      if (e !== 1'b1 || act !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_counts_cleared: err=%b active=%b expected err=1 active=0", e, act);
      end
   endtask

   task automatic test_exact_multiple();
      logic [11:0] exp_b [12] = '{12'h001, 12'h002, 12'h010, 12'h020, 12'h100, 12'h000,
                                  12'h200, 12'h001, 12'h300, 12'h000, 12'h408, 12'h001};
      logic e;
      wr_vec(8'h01, e); wr_vec(8'h02, e);
      wr_nz(8'h10, 7'd0, 1'b0);
      wr_nz(8'h20, 7'd1, 1'b0);
      wr_nz(8'h30, 7'd0, 1'b0);
      wr_nz(8'h40, 7'd1, 1'b1);
      run_frame(8'd1, 8'd2, -1);
      n_checks++;
      if (cap.size() !== 12) begin
         n_fail++;
         $display("FAIL exact_length: got %0d beats expected 12", cap.size());
      end
      for (int i = 0; i < 12; i++) begin
         if (i < cap.size()) begin
            n_checks++;
            if (cap[i] !== exp_b[i]) begin
               n_fail++;
               $display("FAIL exact_beat%0d: got %h expected %h", i, cap[i], exp_b[i]);
            end
         end
      end
      n_checks++;
      if (saw_done !== 1'b1) begin
         n_fail++;
         $display("FAIL exact_done_timeout: done seen=%b expected 1", saw_done);
      end
   endtask

   task automatic test_rejects();
      logic e, act;
      wr_vec(8'h11, e); wr_vec(8'h22, e);
      wr_nz(8'h05, 7'd0, 1'b1);
      pulse_start(8'd1, 8'd3, e, act);
      n_checks++;
      if (e !== 1'b1 || act !== 1'b0) begin
         n_fail++;
         $display("FAIL reject_vec_cnt: err=%b active=%b expected err=1 active=0", e, act);
      end
      wr_vec(8'h33, e);
      wr_nz(8'h06, 7'd1, 1'b0);
      pulse_start(8'd1, 8'd3, e, act);
      n_checks++;
      if (e !== 1'b1 || act !== 1'b0) begin
         n_fail++;
         $display("FAIL reject_tail_last: err=%b active=%b expected err=1 active=0", e, act);
      end
      wr_nz(8'h07, 7'd2, 1'b1);
      run_frame(8'd2, 8'd3, -1);
      n_checks++;
      if (cap.size() !== 13 || saw_done !== 1'b1) begin
         n_fail++;
         $display("FAIL reject_then_accept: got %0d beats done=%b expected 13 done=1", cap.size(), saw_done);
      end
   endtask

   task automatic test_write_while_busy();
      logic [11:0] exp_b [12] = '{12'h001, 12'h002, 12'h010, 12'h020, 12'h090, 12'h000,
                                  12'h088, 12'h001, 12'h000, 12'h000, 12'h000, 12'h000};
      logic e;
      wr_vec(8'h01, e); wr_vec(8'h02, e);
      wr_nz(8'h09, 7'd0, 1'b0);
      wr_nz(8'h08, 7'd1, 1'b1);
      run_frame(8'd1, 8'd2, 3);
      n_checks++;
      if (err_seen !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_write_err: err seen=%b expected 1", err_seen);
      end
      n_checks++;
      if (cap.size() !== 12) begin
         n_fail++;
         $display("FAIL busy_length: got %0d beats expected 12", cap.size());
      end
      for (int i = 0; i < 12; i++) begin
         if (i < cap.size()) begin
            n_checks++;
            if (cap[i] !== exp_b[i]) begin
               n_fail++;
               $display("FAIL busy_beat%0d: got %h expected %h", i, cap[i], exp_b[i]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic e, any_e;
      any_e = 1'b0;
      for (int i = 0; i < 128; i++) begin
         wr_vec(8'(i), e);
         any_e = any_e | e;
      end
      n_checks++;
      if (any_e !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_fill: err=%b expected 0", any_e);
      end
      wr_vec(8'hAA, e);
      n_checks++;
      if (e !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_129th: err=%b expected 1", e);
      end
      do_reset();
   endtask

   task automatic test_async_reset();
      logic e, act;
      wr_vec(8'h01, e); wr_vec(8'h02, e); wr_vec(8'h03, e);
      wr_nz(8'h04, 7'd0, 1'b1);
      @(negedge clk);
      bus.rows  = 8'd1;
      bus.cols  = 8'd3;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (bus.tx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL async_pre_valid: got %b expected 1", bus.tx_valid);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_drop: valid=%b busy=%b expected 0 0", bus.tx_valid, bus.busy);
      end
      @(negedge clk);
      rst = 1'b0;
      pulse_start(8'd1, 8'd3, e, act);
      n_checks++;
      if (e !== 1'b1 || act !== 1'b0) begin
         n_fail++;
         $display("FAIL async_buffers_empty: err=%b active=%b expected err=1 active=0", e, act);
      end
   endtask

   task automatic test_large_index();
      logic e;
      for (int i = 0; i < 128; i++) wr_vec(8'(i), e);
      wr_nz(8'h01, 7'd127, 1'b1);
      run_frame(8'd1, 8'd128, -1);
      n_checks++;
      if (cap.size() !== 138) begin
         n_fail++;
         $display("FAIL large_length: got %0d beats expected 138", cap.size());
      end
      if (cap.size() >= 132) begin
         n_checks++;
         if (cap[1] !== 12'h080) begin
            n_fail++;
            $display("FAIL large_cols_hdr: got %h expected 080", cap[1]);
         end
         n_checks++;
         if (cap[129] !== 12'h7F0) begin
            n_fail++;
            $display("FAIL large_last_vec: got %h expected 7f0", cap[129]);
         end
         n_checks++;
         if (cap[130] !== 12'h018) begin
            n_fail++;
            $display("FAIL large_val: got %h expected 018", cap[130]);
         end
         n_checks++;
         if (cap[131] !== 12'h07F) begin
            n_fail++;
            $display("FAIL large_index: got %h expected 07f", cap[131]);
         end
      end
      n_checks++;
      if (saw_done !== 1'b1) begin
         n_fail++;
         $display("FAIL large_done_timeout: done seen=%b expected 1", saw_done);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_exact_multiple();
      test_rejects();
      test_write_while_busy();
      test_overflow();
      test_async_reset();
      test_large_index();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
